// File: rtl/cordic_bus_mux_pipe.sv
// -----------------------------------------------------------------------------
// cordic_bus_mux_pipe
//   Registered N-to-1 operand bus multiplexer in front of the CORDIC iteration
//   stages. One of NCH input channels is granted, either by the explicit
//   select input (MODE=0) or by round-robin arbitration (MODE=1). The granted
//   word passes through a single output register.
//
// Handshake (valid/ready, identical on every channel and on the output):
//   a word moves across an interface on a rising clk edge where valid and
//   ready are both high. The producer holds valid and data stable until that
//   edge. Ready may depend combinationally on the consumer's ready. There is
//   no skid buffer, so in_ready follows out_ready in the same cycle.
//
// Parameters
//   WIDTH  data width per channel
//   NCH    number of input channels (2..16)
//   SELW   channel index width, equal to clog2(NCH)
//   MODE   0 = explicit select, 1 = round-robin (sel ignored)
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous, active-high
//   in_data    channel i is bits [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready
//   sel        channel select (MODE=0 only)
//   out_data   registered selected word
//   out_chan   index of the channel that produced out_data
//   out_valid  out_data/out_chan hold a valid word
//   out_ready  downstream accepts the word
// -----------------------------------------------------------------------------
module cordic_bus_mux_pipe #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int MODE  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  logic             space;
  logic             gv;
  logic [SELW-1:0]  g;
  logic [SELW-1:0]  cand;
  logic [WIDTH-1:0] g_data;
  logic             load;
  int               idx;

  // Output register can take a new word when empty or being popped now.
  assign space = !out_valid_q | out_ready;

  // Grant selection. In round-robin mode the candidates are visited from the
  // farthest distance back to rr_ptr itself, so the last hit is the closest
  // valid channel at or after rr_ptr (modulo NCH).
  always_comb begin
    gv   = 1'b0;
    g    = '0;
    cand = '0;
    idx  = 0;
    if (MODE == 0) begin
      g = sel;
      for (int i = 0; i < NCH; i++) begin
        if (sel == SELW'(i)) gv = in_valid[i];
      end
    end else begin
      for (int k = NCH - 1; k >= 0; k--) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NCH) idx = idx - NCH;
        cand = SELW'(idx);
        for (int i = 0; i < NCH; i++) begin
          if (cand == SELW'(i) && in_valid[i]) begin
            gv = 1'b1;
            g  = cand;
          end
        end
      end
    end
  end

  // Data mux; out-of-range selects give zero but never load.
  always_comb begin
    g_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (g == SELW'(i)) g_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign load = space & gv & !reset;

  // In select mode ready follows sel alone, independent of in_valid.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      if (MODE == 0) begin
        in_ready[i] = space & !reset & (sel == SELW'(i));
      end else begin
        in_ready[i] = space & gv & !reset & (g == SELW'(i));
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_data_d  = g_data;
      out_chan_d  = g;
      out_valid_d = 1'b1;
      if (MODE != 0) begin
        rr_ptr_d = (g == SELW'(NCH - 1)) ? '0 : g + SELW'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cordic_bus_mux_pipe.sv
// -----------------------------------------------------------------------------
// tb_cordic_bus_mux_pipe
//   Three instances run side by side on one clock and reset:
//     slot 0: MODE=0, NCH=4
//     slot 1: MODE=1, NCH=4
//     slot 2: MODE=0, NCH=3 (leaves sel=3 illegal)
//   A behavioural model per slot predicts in_ready before each edge and the
//   output register after it. Slot 1 additionally keeps a queue of the words
//   it must deliver, popped when the DUT hands a word downstream.
// -----------------------------------------------------------------------------
module tb_cordic_bus_mux_pipe;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Stimulus per slot
  logic [63:0] in_d[3];
  logic [3:0]  in_v[3];
  logic [1:0]  sel_a[3];
  logic        our[3];

  // DUT outputs
  logic [3:0]  rdy0, rdy1;
  logic [2:0]  rdy2;
  logic [W-1:0] od0, od1, od2;
  logic [1:0]  oc0, oc1, oc2;
  logic        ov0, ov1, ov2;

  cordic_bus_mux_pipe #(.WIDTH(W), .NCH(4), .SELW(2), .MODE(0)) u_sel4 (
    .clk(clk), .reset(rst), .in_data(in_d[0]), .in_valid(in_v[0]),
    .in_ready(rdy0), .sel(sel_a[0]), .out_data(od0), .out_chan(oc0),
    .out_valid(ov0), .out_ready(our[0])
  );

  cordic_bus_mux_pipe #(.WIDTH(W), .NCH(4), .SELW(2), .MODE(1)) u_rr4 (
    .clk(clk), .reset(rst), .in_data(in_d[1]), .in_valid(in_v[1]),
    .in_ready(rdy1), .sel(sel_a[1]), .out_data(od1), .out_chan(oc1),
    .out_valid(ov1), .out_ready(our[1])
  );

  cordic_bus_mux_pipe #(.WIDTH(W), .NCH(3), .SELW(2), .MODE(0)) u_sel3 (
    .clk(clk), .reset(rst), .in_data(in_d[2][47:0]), .in_valid(in_v[2][2:0]),
    .in_ready(rdy2), .sel(sel_a[2]), .out_data(od2), .out_chan(oc2),
    .out_valid(ov2), .out_ready(our[2])
  );

  // Slot configuration
  int slot_nch[3]  = '{4, 4, 3};
  int slot_mode[3] = '{0, 1, 0};

  // Model state per slot
  bit          mv[3];
  logic [W-1:0] md[3];
  logic [1:0]  mc[3];
  int          mrr[3];

  logic [17:0] exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Which channel wins this cycle, by the rules stated in terms of channel
  // numbers and modular distance from the round-robin pointer.
  function automatic void model_grant(input int k, output bit gv, output int g);
    gv = 0;
    g  = 0;
    if (slot_mode[k] == 0) begin
      g = int'(sel_a[k]);
      gv = (g < slot_nch[k]) && in_v[k][g];
    end else begin
      for (int s = 0; s < slot_nch[k]; s++) begin
        int c;
        c = (mrr[k] + s) % slot_nch[k];
        if (!gv && in_v[k][c]) begin
          gv = 1;
          g  = c;
        end
      end
    end
  endfunction

  // One clock: inputs already driven by the caller.
  task automatic tick();
    bit gv;
    int g;
    bit sp;
    logic [3:0] er;
    logic [3:0] rdy_a[3];
    logic [W-1:0] od_a[3];
    logic [1:0] oc_a[3];
    logic ov_a[3];
    logic [17:0] front;
    #1;
    rdy_a[0] = rdy0;
    rdy_a[1] = rdy1;
    rdy_a[2] = {1'b0, rdy2};
    for (int k = 0; k < 3; k++) begin
      model_grant(k, gv, g);
      sp = !mv[k] || our[k];
      er = '0;
      if (!rst && sp) begin
        if (slot_mode[k] == 0) begin
          if (int'(sel_a[k]) < slot_nch[k]) er[sel_a[k]] = 1'b1;
        end else if (gv) begin
          er[g] = 1'b1;
        end
      end
      check($sformatf("in_ready[s%0d]", k), 32'(rdy_a[k]), 32'(er));
    end
    // Slot 1 delivery: compare the word leaving against the oldest expected.
    if (!rst && ov1 && our[1]) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(ov1), 32'd0);
      end else begin
        front = exp_q.pop_front();
        check("sb_word", {14'd0, oc1, od1}, {14'd0, front});
      end
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      model_grant(k, gv, g);
      sp = !mv[k] || our[k];
      if (rst) begin
        mv[k] = 0; md[k] = '0; mc[k] = '0; mrr[k] = 0;
      end else if (sp && gv) begin
        mv[k] = 1;
        md[k] = in_d[k][g*W +: W];
        mc[k] = 2'(g);
        mrr[k] = (g + 1) % slot_nch[k];
        if (k == 1) exp_q.push_back({mc[k], md[k]});
      end else if (our[k]) begin
        mv[k] = 0;
      end
    end
    if (rst) exp_q.delete();
    #1;
    od_a[0] = od0; od_a[1] = od1; od_a[2] = od2;
    oc_a[0] = oc0; oc_a[1] = oc1; oc_a[2] = oc2;
    ov_a[0] = ov0; ov_a[1] = ov1; ov_a[2] = ov2;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("out_valid[s%0d]", k), 32'(ov_a[k]), 32'(mv[k]));
      check($sformatf("out_data[s%0d]", k), 32'(od_a[k]), 32'(md[k]));
      check($sformatf("out_chan[s%0d]", k), 32'(oc_a[k]), 32'(mc[k]));
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      in_d[k] = '0; in_v[k] = '0; sel_a[k] = '0; our[k] = 1'b1;
      mv[k] = 0; md[k] = '0; mc[k] = '0; mrr[k] = 0;
    end

    // Reset with every channel requesting
    rst = 1'b1;
    for (int k = 0; k < 3; k++) in_v[k] = 4'hF;
    tick();
    tick();
    check("reset_ov", 32'(ov1), 32'd0);
    check("reset_rdy", 32'(rdy0), 32'd0);

    // Round-robin fairness right after reset: first grant ch0, then rotate
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rr_seq_chan", 32'(oc1), 32'(i % 4));
      check("rr_seq_valid", 32'(ov1), 32'd1);
    end

    // Explicit select of ch2
    in_v[0] = 4'b0100; sel_a[0] = 2'd2; our[0] = 1'b1;
    in_d[0] = 64'h0;
    in_d[0][47:32] = 16'hBEEF;
    tick();
    check("sel_data", 32'(od0), 32'h0000BEEF);
    check("sel_chan", 32'(oc0), 32'd2);

    // Stall: inputs wander, word must hold
    our[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_d[0] = {$urandom, $urandom};
      sel_a[0] = 2'($urandom_range(0, 3));
      in_v[0] = 4'hF;
      tick();
      check("stall_data", 32'(od0), 32'h0000BEEF);
      check("stall_rdy", 32'(rdy0), 32'd0);
    end
    // Pop and load in the same clock
    our[0] = 1'b1; sel_a[0] = 2'd1; in_v[0] = 4'b0010;
    in_d[0][31:16] = 16'h1234;
    tick();
    check("popload_data", 32'(od0), 32'h00001234);
    check("popload_chan", 32'(oc0), 32'd1);

    // Sparse round-robin: move pointer to 2, then only ch0/ch1 request
    rst = 1'b1; tick(); rst = 1'b0;
    in_v[1] = 4'b0010; our[1] = 1'b1;
    tick();
    check("sparse_pre", 32'(oc1), 32'd1);
    in_v[1] = 4'b0011;
    tick();
    check("sparse_wrap", 32'(oc1), 32'd0);
    tick();
    check("sparse_next", 32'(oc1), 32'd1);

    // Reset while a word is stalled: it must never appear
    in_v[0] = 4'b0001; sel_a[0] = 2'd0; in_d[0][15:0] = 16'hAAAA; our[0] = 1'b1;
    tick();
    our[0] = 1'b0;
    tick();
    check("held_word", 32'(od0), 32'h0000AAAA);
    rst = 1'b1;
    tick();
    rst = 1'b0; in_v[0] = 4'b0000; our[0] = 1'b1;
    tick();
    check("reset_drop", 32'(ov0), 32'd0);

    // Illegal select on the 3-channel instance
    sel_a[2] = 2'd3; in_v[2] = 4'b0111; our[2] = 1'b1;
    tick();
    tick();
    check("illegal_ov", 32'(ov2), 32'd0);
    check("illegal_rdy", 32'(rdy2), 32'd0);

    // Random traffic on all slots
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < 3; k++) begin
        in_d[k]  = {$urandom, $urandom};
        in_v[k]  = 4'($urandom_range(0, 15));
        sel_a[k] = 2'($urandom_range(0, 3));
        our[k]   = ($urandom_range(0, 3) != 0);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
